// File: rtl/lfsr_param_if.sv
// Control and observation bundle for lfsr_param.
// PeriodLen exists only when LFSR_PERIOD_COUNT_EN is defined.
interface lfsr_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             Load;
    logic             Enable;
    logic [WIDTH-1:0] initialValue;
    logic             Z;
    logic [WIDTH-1:0] State;
    logic             LockUp;
    logic             PeriodDone;
`ifdef LFSR_PERIOD_COUNT_EN
    logic [WIDTH-1:0] PeriodLen;

    modport master (
        output Load, Enable, initialValue,
        input  Z, State, LockUp, PeriodDone, PeriodLen
    );
    modport slave (
        input  Load, Enable, initialValue,
        output Z, State, LockUp, PeriodDone, PeriodLen
    );
`else
    modport master (
        output Load, Enable, initialValue,
        input  Z, State, LockUp, PeriodDone
    );
    modport slave (
        input  Load, Enable, initialValue,
        output Z, State, LockUp, PeriodDone
    );
`endif
endinterface

// File: rtl/lfsr_param.sv
// Parametrised Fibonacci LFSR with lock-up recovery and period detection.
// Optional LFSR_PERIOD_COUNT_EN adds a period-length counter and PeriodLen output.
module lfsr_param #(
    parameter int unsigned     WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(4'b0001)
) (
    input  logic       Clock,
    input  logic       Reset,
    lfsr_param_if.slave bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]       fsm_q, fsm_n;
    logic [WIDTH-1:0] seed_q, seed_n;
    logic [WIDTH-1:0] state_n;
    logic [WIDTH-1:0] shifted;
    logic             z_n, lock_n, done_n;
    logic             fb;
    logic             is_zero;

`ifdef LFSR_PERIOD_COUNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] plen_n;
`endif

    assign fb      = ^(bus.State & TAPS);
    assign shifted = {bus.State[WIDTH-2:0], fb};
    assign is_zero = (bus.State == '0);

    // Control FSM next state; RECOVER lasts one cycle and always falls back to RUN.
    always_comb begin
        fsm_n = fsm_q;
        if (bus.Load) begin
            fsm_n = ST_RUN;
        end else if (fsm_q == ST_RECOVER) begin
            fsm_n = ST_RUN;
        end else if (bus.Enable && is_zero) begin
            fsm_n = ST_RECOVER;
        end else if (bus.Enable) begin
            fsm_n = ST_RUN;
        end else begin
            fsm_n = ST_HOLD;
        end
    end

    // Datapath next state: Load > lock-up recovery > advance > hold.
    always_comb begin
        state_n = bus.State;
        seed_n  = seed_q;
        z_n     = bus.Z;
        lock_n  = 1'b0;
        done_n  = 1'b0;
`ifdef LFSR_PERIOD_COUNT_EN
        cnt_n   = cnt_q;
        plen_n  = bus.PeriodLen;
`endif
        if (bus.Load) begin
            state_n = bus.initialValue;
            seed_n  = bus.initialValue;
            z_n     = 1'b0;
`ifdef LFSR_PERIOD_COUNT_EN
            cnt_n   = '0;
`endif
        end else if (bus.Enable && is_zero) begin
            state_n = RESET_SEED;
            seed_n  = RESET_SEED;
            z_n     = 1'b0;
            lock_n  = 1'b1;
`ifdef LFSR_PERIOD_COUNT_EN
            cnt_n   = '0;
`endif
        end else if (bus.Enable) begin
            state_n = shifted;
            z_n     = bus.State[WIDTH-1];
            done_n  = (shifted == seed_q);
`ifdef LFSR_PERIOD_COUNT_EN
            if (shifted == seed_q) begin
                plen_n = WIDTH'(cnt_q + 1'b1);
                cnt_n  = '0;
            end else begin
                cnt_n  = WIDTH'(cnt_q + 1'b1);
            end
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm_q          <= ST_RUN;
            seed_q         <= RESET_SEED;
            bus.State      <= RESET_SEED;
            bus.Z          <= 1'b0;
            bus.LockUp     <= 1'b0;
            bus.PeriodDone <= 1'b0;
        end else begin
            fsm_q          <= fsm_n;
            seed_q         <= seed_n;
            bus.State      <= state_n;
            bus.Z          <= z_n;
            bus.LockUp     <= lock_n;
            bus.PeriodDone <= done_n;
        end
    end

`ifdef LFSR_PERIOD_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q         <= '0;
            bus.PeriodLen <= '0;
        end else begin
            cnt_q         <= cnt_n;
            bus.PeriodLen <= plen_n;
        end
    end
`endif
endmodule

// File: tb/tb_lfsr_param.sv
// Directed self-checking bench for lfsr_param at the default 4-bit x^4+x^3+1 configuration.
module tb_lfsr_param;
    localparam int unsigned WIDTH = 4;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    lfsr_param_if #(.WIDTH(WIDTH)) bus ();

    lfsr_param #(
        .WIDTH     (WIDTH),
        .TAPS      (4'b1100),
        .RESET_SEED(4'b0001)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    logic [3:0] seq [15];

    initial begin
        checks = 0;
        errors = 0;
        seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

        // 1: reset and hold
        Reset = 1'b1;
        bus.Load = 1'b0;
        bus.Enable = 1'b0;
        bus.initialValue = 4'b0000;
        tick();
        tick();
        check("rst_state", 32'(bus.State), 32'h1);
        check("rst_z", 32'(bus.Z), 32'h0);
        check("rst_lock", 32'(bus.LockUp), 32'h0);
        check("rst_done", 32'(bus.PeriodDone), 32'h0);
`ifdef LFSR_PERIOD_COUNT_EN
        check("rst_plen", 32'(bus.PeriodLen), 32'h0);
`endif
        Reset = 1'b0;
        tick();
        tick();
        check("hold_state", 32'(bus.State), 32'h1);

        // 2: full period from seed 0001
        bus.Load = 1'b1;
        bus.initialValue = 4'b0001;
        tick();
        bus.Load = 1'b0;
        bus.Enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("seq_state_%0d", i), 32'(bus.State), 32'(seq[i]));
            check($sformatf("seq_done_%0d", i), 32'(bus.PeriodDone), (i == 14) ? 32'h1 : 32'h0);
            check($sformatf("seq_lock_%0d", i), 32'(bus.LockUp), 32'h0);
        end
`ifdef LFSR_PERIOD_COUNT_EN
        check("plen_15", 32'(bus.PeriodLen), 32'd15);
`endif
        bus.Enable = 1'b0;
        tick();
        check("done_clears", 32'(bus.PeriodDone), 32'h0);
        check("hold_after_period", 32'(bus.State), 32'h1);

        // 3: serial output lag
        bus.Load = 1'b1;
        bus.initialValue = 4'b0110;
        tick();
        check("load_z_clear", 32'(bus.Z), 32'h0);
        bus.Load = 1'b0;
        bus.Enable = 1'b1;
        tick();
        check("z1_state", 32'(bus.State), 32'hD);
        check("z1_z", 32'(bus.Z), 32'h0);
        tick();
        check("z2_state", 32'(bus.State), 32'hA);
        check("z2_z", 32'(bus.Z), 32'h1);

        // 4: lock-up held while disabled, recovered when enabled
        bus.Enable = 1'b0;
        bus.Load = 1'b1;
        bus.initialValue = 4'b0000;
        tick();
        bus.Load = 1'b0;
        tick();
        tick();
        tick();
        check("zero_held", 32'(bus.State), 32'h0);
        check("zero_nolock", 32'(bus.LockUp), 32'h0);
        bus.Enable = 1'b1;
        tick();
        check("rec_state", 32'(bus.State), 32'h1);
        check("rec_lock", 32'(bus.LockUp), 32'h1);
        check("rec_z", 32'(bus.Z), 32'h0);
        check("rec_done", 32'(bus.PeriodDone), 32'h0);
        tick();
        check("post_rec_state", 32'(bus.State), 32'h2);
        check("post_rec_lock", 32'(bus.LockUp), 32'h0);
`ifdef LFSR_PERIOD_COUNT_EN
        // 4b: recovered seed is 0001, so a full period later PeriodLen is 15 again
        for (int i = 0; i < 14; i++) tick();
        check("rec_period_done", 32'(bus.PeriodDone), 32'h1);
        check("rec_plen", 32'(bus.PeriodLen), 32'd15);
`endif

        // 5: enable toggling from seed 1000
        bus.Enable = 1'b0;
        bus.Load = 1'b1;
        bus.initialValue = 4'b1000;
        tick();
        bus.Load = 1'b0;
        bus.Enable = 1'b1;
        tick();
        check("tog1_state", 32'(bus.State), 32'h1);
        check("tog1_z", 32'(bus.Z), 32'h1);
        check("tog1_done", 32'(bus.PeriodDone), 32'h0);
        bus.Enable = 1'b0;
        tick();
        check("tog2_state", 32'(bus.State), 32'h1);
        check("tog2_z", 32'(bus.Z), 32'h1);
        check("tog2_done", 32'(bus.PeriodDone), 32'h0);
        bus.Enable = 1'b1;
        tick();
        check("tog3_state", 32'(bus.State), 32'h2);
        check("tog3_done", 32'(bus.PeriodDone), 32'h0);
        bus.Enable = 1'b0;
        tick();
        check("tog4_state", 32'(bus.State), 32'h2);
        check("tog4_done", 32'(bus.PeriodDone), 32'h0);

        // 6: priority of Reset over Load over Enable
        bus.Enable = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        bus.Load = 1'b1;
        bus.initialValue = 4'b0110;
        tick();
        check("prio_rst_state", 32'(bus.State), 32'h1);
        check("prio_rst_z", 32'(bus.Z), 32'h0);
        Reset = 1'b0;
        bus.initialValue = 4'b1011;
        tick();
        check("prio_load_state", 32'(bus.State), 32'hB);
        check("prio_load_z", 32'(bus.Z), 32'h0);
        bus.Load = 1'b0;
        tick();
        check("after_load_state", 32'(bus.State), 32'h7);
        check("after_load_z", 32'(bus.Z), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
